// File: rtl/ppu_pkg.sv
// ============================================================================
// Module      : ppu_pkg
// Description : Shared PPU tile-geometry helpers and the OARAM reader state set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ppu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LEN_REQ  = 4'd1,
        ST_LEN_WAIT = 4'd2,
        ST_FETCH    = 4'd3,
        ST_WAIT     = 4'd4,
        ST_EMIT_Z   = 4'd5,
        ST_EMIT_V   = 4'd6,
        ST_PAD      = 4'd7,
        ST_DONE     = 4'd8
    } reader_state_e;

    // Lower precisions pack more activations per word, shrinking the real tile edge.
    function automatic int unsigned actual_tile_size(input int unsigned tile_size,
                                                     input logic [1:0]  bitwidth);
        case (bitwidth)
            2'd1:    return tile_size >> 1;
            2'd2:    return tile_size >> 3;
            default: return tile_size;
        endcase
    endfunction

    function automatic int unsigned halo_size(input logic [2:0] kernel_size);
        if (kernel_size == 3'd0) return 32'd0;
        return 32'((kernel_size - 3'd1) >> 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/oaram_stream_reader_center_raster_counter.sv
// ============================================================================
// Module      : center_raster_counter
// Description : Raster row/column and emitted-pixel counter for the tile center.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module center_raster_counter #(
    parameter int TW = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear,
    input  logic            advance,
    input  logic [TW:0]     dim,
    output logic [TW-1:0]   row,
    output logic [TW-1:0]   column,
    output logic [2*TW:0]   emitted,
    output logic            at_last
);

    localparam logic [TW:0]   DIM_ONE = {{TW{1'b0}}, 1'b1};
    localparam logic [TW-1:0] POS_ONE = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [2*TW:0] CNT_ONE = {{(2*TW){1'b0}}, 1'b1};

    logic [TW-1:0] row_q, row_d, column_q, column_d;
    logic [2*TW:0] emitted_q, emitted_d;
    logic [2*TW:0] w_total;

    assign w_total = {{TW{1'b0}}, dim} * {{TW{1'b0}}, dim};

    always_comb begin
        row_d     = row_q;
        column_d  = column_q;
        emitted_d = emitted_q;
        if (clear) begin
            row_d     = '0;
            column_d  = '0;
            emitted_d = '0;
        end else if (advance) begin
            emitted_d = emitted_q + CNT_ONE;
            if ({1'b0, column_q} == dim - DIM_ONE) begin
                column_d = '0;
                row_d    = row_q + POS_ONE;
            end else begin
                column_d = column_q + POS_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q     <= '0;
            column_q  <= '0;
            emitted_q <= '0;
        end else begin
            row_q     <= row_d;
            column_q  <= column_d;
            emitted_q <= emitted_d;
        end
    end

    assign row     = row_q;
    assign column  = column_q;
    assign emitted = emitted_q;
    assign at_last = (emitted_q == w_total - CNT_ONE);

endmodule

`default_nettype wire

// File: rtl/oaram_stream_reader.sv
// ============================================================================
// Module      : oaram_stream_reader
// Description : Expands a run-length compressed OARAM tile into a dense stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oaram_stream_reader
    import ppu_pkg::*;
#(
    parameter int  RAM_WIDTH   = 14,
    parameter int  TILE_SIZE   = 256,
    parameter int  INDEX_WIDTH = 4,
    localparam int TW          = $clog2(TILE_SIZE)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             bitwidth,
    input  logic [2:0]             kernel_size,
    input  logic                   start,
    output logic                   oaram_read_enable,
    output logic [RAM_WIDTH-2:0]   oaram_read_address,
    input  logic [24:0]            oaram_read_value,
    input  logic [INDEX_WIDTH-1:0] oaram_read_index,
    output logic                   act_valid,
    input  logic                   act_ready,
    output logic [7:0]             act_value,
    output logic [TW-1:0]          act_row,
    output logic [TW-1:0]          act_column,
    output logic                   act_last,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    localparam int AW = RAM_WIDTH - 1;
    localparam int DW = TW + 1;
    localparam int CW = 2 * TW + 1;
    localparam logic [AW-1:0]          K_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [INDEX_WIDTH-1:0] Z_ONE = {{(INDEX_WIDTH-1){1'b0}}, 1'b1};

    reader_state_e          state_q, state_d;
    logic [AW-1:0]          len_q, len_d, k_q, k_d;
    logic [INDEX_WIDTH-1:0] zeros_left_q, zeros_left_d;
    logic [7:0]             val_q, val_d;
    logic [TW:0]            dim_q, dim_d, w_dim_start;
    logic                   error_q, error_d;
    logic                   w_clear, w_handshake, w_at_last, w_pad_full;
    logic [CW-1:0]          w_emitted, w_total;

    assign w_dim_start = DW'(actual_tile_size(TILE_SIZE, bitwidth) - 2 * halo_size(kernel_size));
    assign w_total     = {{TW{1'b0}}, dim_q} * {{TW{1'b0}}, dim_q};
    assign w_pad_full  = (w_emitted == w_total);
    assign w_clear     = (state_q == ST_IDLE) && start;
    assign w_handshake = act_valid && act_ready;

    center_raster_counter #(.TW(TW)) u_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_clear),
        .advance (w_handshake),
        .dim     (dim_q),
        .row     (act_row),
        .column  (act_column),
        .emitted (w_emitted),
        .at_last (w_at_last)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        k_d          = k_q;
        zeros_left_d = zeros_left_q;
        val_d        = val_q;
        dim_d        = dim_q;
        error_d      = error_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LEN_REQ;
                    error_d = 1'b0;
                    dim_d   = w_dim_start;
                end
            end
            ST_LEN_REQ: state_d = ST_LEN_WAIT;
            ST_LEN_WAIT: begin
                len_d = oaram_read_value[RAM_WIDTH-2:0];
                if (|oaram_read_value[24:RAM_WIDTH-1]) begin
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end else if (oaram_read_value[RAM_WIDTH-2:0] == '0) begin
                    state_d = ST_PAD;
                end else begin
                    k_d     = K_ONE;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            // Zero-length runs skip straight to the value so no bubble is spent.
            ST_WAIT: begin
                zeros_left_d = oaram_read_index;
                val_d        = oaram_read_value[7:0];
                state_d      = (oaram_read_index != '0) ? ST_EMIT_Z : ST_EMIT_V;
            end
            ST_EMIT_Z: begin
                if (w_handshake) begin
                    zeros_left_d = zeros_left_q - Z_ONE;
                    if (w_at_last) begin
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end else if (zeros_left_q == Z_ONE) begin
                        state_d = ST_EMIT_V;
                    end
                end
            end
            ST_EMIT_V: begin
                if (w_handshake) begin
                    k_d = k_q + K_ONE;
                    if (w_at_last) begin
                        if (k_q != len_q) error_d = 1'b1;
                        state_d = ST_DONE;
                    end else if (k_q == len_q) begin
                        state_d = ST_PAD;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_PAD: begin
                if (w_pad_full || (w_handshake && w_at_last)) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            k_q          <= '0;
            zeros_left_q <= '0;
            val_q        <= '0;
            dim_q        <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            k_q          <= k_d;
            zeros_left_q <= zeros_left_d;
            val_q        <= val_d;
            dim_q        <= dim_d;
            error_q      <= error_d;
        end
    end

    assign oaram_read_enable  = (state_q == ST_LEN_REQ) || (state_q == ST_FETCH);
    assign oaram_read_address = (state_q == ST_FETCH) ? k_q : '0;
    assign act_valid          = (state_q == ST_EMIT_Z) || (state_q == ST_EMIT_V) ||
                                ((state_q == ST_PAD) && !w_pad_full);
    assign act_value          = (state_q == ST_EMIT_V) ? val_q : 8'd0;
    assign act_last           = act_valid && w_at_last;
    assign busy               = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done               = (state_q == ST_DONE);
    assign error              = error_q;

endmodule

`default_nettype wire
